// File: rtl/alu32.sv
// Registered 32-bit ALU: arithmetic, logic, shift and compare with Zero/Carry/Overflow, one-cycle latency.
// Define ALU32_EXT_OPS_EN to enable SLTU, NOR and PASSB on opcodes 1010-1100.
module alu32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_Sel,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Carry,
  output logic        Overflow
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_LSL = 4'b0110;
  localparam logic [3:0] OP_LSR = 4'b0111;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
`ifdef ALU32_EXT_OPS_EN
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1011;
  localparam logic [3:0] OP_PASSB = 4'b1100;
`endif

  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic [31:0] and_bits;
  logic [31:0] or_bits;
  logic [31:0] xor_bits;
  logic [31:0] result_next;
  logic        carry_next;
  logic        overflow_next;
  logic [31:0] result_reg;
  logic        zero_reg;
  logic        carry_reg;
  logic        overflow_reg;

  // Subtraction as A + ~B + 1 so bit 32 is the no-borrow flag.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} + {1'b0, ~B} + 33'd1;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bitwise
      assign and_bits[gi] = A[gi] & B[gi];
      assign or_bits[gi]  = A[gi] | B[gi];
      assign xor_bits[gi] = A[gi] ^ B[gi];
    end
  endgenerate

  always_comb begin
    result_next   = 32'd0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        result_next   = sum_ext[31:0];
        carry_next    = sum_ext[32];
        overflow_next = (A[31] == B[31]) && (sum_ext[31] != A[31]);
      end
      OP_SUB: begin
        result_next   = diff_ext[31:0];
        carry_next    = diff_ext[32];
        overflow_next = (A[31] != B[31]) && (diff_ext[31] != A[31]);
      end
      OP_AND: result_next = and_bits;
      OP_OR:  result_next = or_bits;
      OP_XOR: result_next = xor_bits;
      OP_NOT: result_next = ~A;
      OP_LSL: result_next = A << B[4:0];
      OP_LSR: result_next = A >> B[4:0];
      OP_ASR: result_next = $unsigned($signed(A) >>> B[4:0]);
      OP_SLT: result_next = {31'd0, $signed(A) < $signed(B)};
`ifdef ALU32_EXT_OPS_EN
      OP_SLTU:  result_next = {31'd0, A < B};
      OP_NOR:   result_next = ~or_bits;
      OP_PASSB: result_next = B;
`endif
      default: result_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= 32'd0;
      zero_reg     <= 1'b1;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      result_reg   <= result_next;
      zero_reg     <= (result_next == 32'd0);
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
    end
  end

  assign Result   = result_reg;
  assign Zero     = zero_reg;
  assign Carry    = carry_reg;
  assign Overflow = overflow_reg;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: arithmetic reference model, per-cycle compare, directed and random stimulus.
`timescale 1ns/1ps
module tb_alu32;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Sel;
  logic [31:0] Result;
  logic        Zero;
  logic        Carry;
  logic        Overflow;

  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;
  exp_t exp_out = '{r: 32'd0, z: 1'b1, c: 1'b0, v: 1'b0};

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .Result   (Result),
    .Zero     (Zero),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain wide integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int unsigned     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    e  = '0;
    case (op)
      4'd0: begin
        e.r = 32'(ua + ub);
        e.c = (ua + ub) > 64'hFFFF_FFFF;
        e.v = (sa + sb > SMAX) || (sa + sb < SMIN);
      end
      4'd1: begin
        e.r = 32'(ua - ub);
        e.c = ua >= ub;
        e.v = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = ~a;
      4'd6: e.r = 32'(ua * (64'd1 << sh));
      4'd7: e.r = 32'(ua / (64'd1 << sh));
      4'd8: e.r = 32'(sa >>> sh);
      4'd9: e.r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU32_EXT_OPS_EN
      4'd10: e.r = (ua < ub) ? 32'd1 : 32'd0;
      4'd11: e.r = ~(a | b);
      4'd12: e.r = b;
`endif
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Expected outputs track the DUT's one-cycle latency and asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_out <= '{r: 32'd0, z: 1'b1, c: 1'b0, v: 1'b0};
    else        exp_out <= model(A, B, ALU_Sel);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checks++;
        if (Result !== exp_out.r || Zero !== exp_out.z || Carry !== exp_out.c || Overflow !== exp_out.v) begin
          errors++;
          $display("FAIL cycle_cmp t=%0t: got R=%h Z=%b C=%b V=%b, want R=%h Z=%b C=%b V=%b",
                   $time, Result, Zero, Carry, Overflow, exp_out.r, exp_out.z, exp_out.c, exp_out.v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [34:0] got, input logic [34:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    A       = a;
    B       = b;
    ALU_Sel = s;
    @(negedge clk);
  endtask

  task automatic rand_ops(input int n);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = $urandom_range(0, 40);
        1: b = a;
        2: a = {1'b1, 31'($urandom_range(0, 3))};
        default: ;
      endcase
      op(a, b, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    ALU_Sel = 4'd0;

    // Hand-computed anchors for the model: {r, z, c, v}
    chk("model_add_ovf",  model(32'h7FFF_FFFF, 32'd1, 4'd0), {32'h8000_0000, 1'b0, 1'b0, 1'b1});
    chk("model_add_wrap", model(32'hFFFF_FFFF, 32'd1, 4'd0), {32'h0000_0000, 1'b1, 1'b1, 1'b0});
    chk("model_sub_ok",   model(32'd30, 32'd15, 4'd1),       {32'd15,        1'b0, 1'b1, 1'b0});
    chk("model_sub_brw",  model(32'd0, 32'd1, 4'd1),         {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    chk("model_and",      model(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2), {32'h0F00_0F00, 3'b000});
    chk("model_or",       model(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd3), {32'hFF0F_FF0F, 3'b000});
    chk("model_xor",      model(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd4), {32'hF00F_F00F, 3'b000});
    chk("model_not",      model(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd5), {32'h00FF_00FF, 3'b000});
    chk("model_lsl",      model(32'd1, 32'd4, 4'd6),         {32'h0000_0010, 3'b000});
    chk("model_lsr_zero", model(32'd1, 32'd4, 4'd7),         {32'h0000_0000, 3'b100});
    chk("model_asr",      model(32'h8000_0000, 32'd4, 4'd8), {32'hF800_0000, 3'b000});
    chk("model_lsr_msb",  model(32'h8000_0000, 32'd4, 4'd7), {32'h0800_0000, 3'b000});
    chk("model_slt",      model(32'hFFFF_FFFB, 32'd3, 4'd9), {32'd1,         3'b000});
    // SLTU with the extension, an unused opcode without it: zero either way.
    chk("model_op1010",   model(32'hFFFF_FFFB, 32'd3, 4'd10), {32'd0,        3'b100});

    repeat (3) @(negedge clk);
    chk("reset_outputs", {Result, Zero, Carry, Overflow}, {32'd0, 3'b100});
    check_en = 1'b1;

    rst_n = 1'b1;
    op(32'd10, 32'd20, 4'd0);
    chk("first_add", {Result, Zero, Carry, Overflow}, {32'd30, 3'b000});

    // Directed sequence, issued back to back.
    op(32'd30,         32'd15,         4'd1);
    op(32'd0,          32'd1,          4'd1);
    op(32'h7FFF_FFFF,  32'd1,          4'd0);
    op(32'hFFFF_FFFF,  32'd1,          4'd0);
    op(32'h8000_0000,  32'hFFFF_FFFF,  4'd0);
    op(32'h8000_0000,  32'd1,          4'd1);
    op(32'hFF00_FF00,  32'h0F0F_0F0F,  4'd2);
    op(32'hFF00_FF00,  32'h0F0F_0F0F,  4'd3);
    op(32'hFF00_FF00,  32'h0F0F_0F0F,  4'd4);
    op(32'hFF00_FF00,  32'h0F0F_0F0F,  4'd5);
    op(32'd1,          32'd4,          4'd6);
    op(32'd1,          32'd4,          4'd7);
    op(32'h8000_0000,  32'd4,          4'd8);
    op(32'h8000_0000,  32'd4,          4'd7);
    op(32'h8000_0000,  32'hFFFF_FFE0,  4'd8);
    op(32'h8000_0000,  32'd31,         4'd8);
    op(32'hFFFF_FFFB,  32'd3,          4'd9);
    for (int s = 10; s < 16; s++) op(32'hFFFF_FFFB, 32'd3, 4'(s));
    for (int s = 10; s < 16; s++) op(32'h1234_5678, 32'h9ABC_DEF0, 4'(s));

    rand_ops(2000);

    // Mid-stream asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {Result, Zero, Carry, Overflow}, {32'd0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("hold_after_release", {Result, Zero, Carry, Overflow}, {32'd0, 3'b100});
    op(32'h7FFF_FFFF, 32'd1, 4'd0);
    chk("first_after_reset", {Result, Zero, Carry, Overflow}, {32'h8000_0000, 3'b001});

    rand_ops(1000);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
